alu_operand_stage: RTL and testbench

- Registered operand-select stage directly upstream of the ALU. Single-entry ID/EX pipeline register with a valid/ready handshake.
- Takes register-file read data, PC, immediate and the decoded ALU op from decode.
- Resolves EX and WB forwarding and applies operand-select muxing, then presents stable A, B and alu_op to the ALU.
- Flush support for branch redirect.

---
 rtl/alu_operand_stage.sv | 141 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand-select register: resolves EX/WB forwarding, muxes A/B, valid/ready handshake with flush.
// Optional ALU_OP_CHECK_EN: illegal alu_op codes are replaced by ADD and flagged on err_illegal_op.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_a_sel,
  input  logic                  in_b_sel,
  input  logic [3:0]            in_alu_op,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_rd_we,
  input  logic                  fwd_ex_we,
  input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
  input  logic [XLEN-1:0]       fwd_ex_data,
  input  logic                  fwd_wb_we,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_a,
  output logic [XLEN-1:0]       alu_b,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_rd_we
`ifdef ALU_OP_CHECK_EN
  ,
  output logic                  err_illegal_op
`endif
);

  localparam logic [3:0] OP_MAX = 4'b1010;

  logic                  r_valid;
  logic [XLEN-1:0]       r_alu_a;
  logic [XLEN-1:0]       r_alu_b;
  logic [3:0]            r_alu_op;
  logic [XLEN-1:0]       r_rs2_val;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_we;

  logic                  w_capture;
  logic [XLEN-1:0]       w_rs1_fwd;
  logic [XLEN-1:0]       w_rs2_fwd;
  logic [3:0]            w_alu_op;

  // EX beats WB beats regfile; x0 is hard-wired and never forwarded.
  function automatic logic [XLEN-1:0] resolve_fwd(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       rf_data,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic [XLEN-1:0]       ex_data,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic [XLEN-1:0]       wb_data
  );
    logic [XLEN-1:0] v;
    v = rf_data;
    if (rs != '0) begin
      if (ex_we && (ex_rd == rs))      v = ex_data;
      else if (wb_we && (wb_rd == rs)) v = wb_data;
    end
    return v;
  endfunction

  function automatic logic [3:0] sanitize_op(input logic [3:0] op);
`ifdef ALU_OP_CHECK_EN
    return (op > OP_MAX) ? 4'b0000 : op;
`else
    return op;
`endif
  endfunction

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  assign w_rs1_fwd = resolve_fwd(in_rs1_addr, in_rs1_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                 fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign w_rs2_fwd = resolve_fwd(in_rs2_addr, in_rs2_data, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                                 fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign w_alu_op  = sanitize_op(in_alu_op);

  // ID/EX register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_rs2_val <= '0;
      r_rd_addr <= '0;
      r_rd_we   <= 1'b0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;

      if (w_capture) begin
        r_alu_a   <= in_a_sel ? in_pc  : w_rs1_fwd;
        r_alu_b   <= in_b_sel ? in_imm : w_rs2_fwd;
        r_alu_op  <= w_alu_op;
        r_rs2_val <= w_rs2_fwd;
        r_rd_addr <= in_rd_addr;
        r_rd_we   <= in_rd_we && (in_rd_addr != '0);
      end
    end
  end

`ifdef ALU_OP_CHECK_EN
  logic r_err;

  // Sticky until reset so software can observe any illegal op seen since boot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_err <= 1'b0;
    else if (w_capture && in_alu_op > OP_MAX) r_err <= 1'b1;
  end

  assign err_illegal_op = r_err;
`endif

  assign out_valid   = r_valid;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign out_rs2_val = r_rs2_val;
  assign out_rd_addr = r_rd_addr;
  assign out_rd_we   = r_rd_we && r_valid;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a transaction-level reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
  logic        in_a_sel, in_b_sel, in_rd_we;
  logic [3:0]  in_alu_op;
  logic        fwd_ex_we, fwd_wb_we;
  logic [4:0]  fwd_ex_rd, fwd_wb_rd;
  logic [31:0] fwd_ex_data, fwd_wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] alu_a, alu_b, out_rs2_val;
  logic [3:0]  alu_op;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;
`ifdef ALU_OP_CHECK_EN
  logic        err_illegal_op;
`endif

  alu_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rs2_val(out_rs2_val), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
`ifdef ALU_OP_CHECK_EN
    , .err_illegal_op(err_illegal_op)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the single instruction currently held by the stage.
  logic        m_valid;
  logic [31:0] m_a, m_b, m_rs2;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        m_rdwe;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (rs == 5'd0) return rf;
    if (fwd_ex_we && fwd_ex_rd == rs) return fwd_ex_data;
    if (fwd_wb_we && fwd_wb_rd == rs) return fwd_wb_data;
    return rf;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_a = '0; m_b = '0; m_rs2 = '0;
    m_op = '0; m_rd = '0; m_rdwe = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid",   32'(out_valid),   32'(m_valid));
    chk("alu_a",       alu_a,            m_a);
    chk("alu_b",       alu_b,            m_b);
    chk("alu_op",      32'(alu_op),      32'(m_op));
    chk("out_rs2_val", out_rs2_val,      m_rs2);
    chk("out_rd_addr", 32'(out_rd_addr), 32'(m_rd));
    chk("out_rd_we",   32'(out_rd_we),   32'(m_valid && m_rdwe));
`ifdef ALU_OP_CHECK_EN
    chk("err_illegal_op", 32'(err_illegal_op), 32'(m_err));
`endif
  endtask

  task automatic set_idle();
    in_valid = 0; out_ready = 1; flush = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0; in_rd_we = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_pc = 0; in_imm = 0;
    in_a_sel = 0; in_b_sel = 0; in_alu_op = 0;
    fwd_ex_we = 0; fwd_ex_rd = 0; fwd_ex_data = 0;
    fwd_wb_we = 0; fwd_wb_rd = 0; fwd_wb_data = 0;
  endtask

  task automatic randomize_fwd();
    fwd_ex_we = 1'($urandom_range(0, 1)); fwd_ex_rd = 5'($urandom_range(0, 3)); fwd_ex_data = $urandom;
    fwd_wb_we = 1'($urandom_range(0, 1)); fwd_wb_rd = 5'($urandom_range(0, 3)); fwd_wb_data = $urandom;
  endtask

  task automatic randomize_inputs();
    in_valid = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 15) == 0);
    in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
    in_rd_addr = 5'($urandom_range(0, 3)); in_rd_we = 1'($urandom_range(0, 1));
    in_rs1_data = $urandom; in_rs2_data = $urandom; in_pc = $urandom; in_imm = $urandom;
    in_a_sel = 1'($urandom_range(0, 1)); in_b_sel = 1'($urandom_range(0, 1));
    in_alu_op = 4'($urandom_range(0, 15));
    randomize_fwd();
  endtask

  // Called with inputs already driven; advances one clock and checks the result.
  task automatic cycle();
    logic        cap;
    logic [31:0] r1, r2;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    cap = in_valid && (!m_valid || out_ready) && !flush;
    r1  = m_fwd(in_rs1_addr, in_rs1_data);
    r2  = m_fwd(in_rs2_addr, in_rs2_data);
    @(posedge clk);
    #1;
    if (flush)          m_valid = 1'b0;
    else if (cap)       m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
    if (cap) begin
      m_a    = in_a_sel ? in_pc : r1;
      m_b    = in_b_sel ? in_imm : r2;
      m_rs2  = r2;
      m_rd   = in_rd_addr;
      m_rdwe = in_rd_we && (in_rd_addr != 0);
`ifdef ALU_OP_CHECK_EN
      m_op   = (in_alu_op > 4'd10) ? 4'd0 : in_alu_op;
      if (in_alu_op > 4'd10) m_err = 1'b1;
`else
      m_op   = in_alu_op;
`endif
    end
    check_outputs();
  endtask

  logic [31:0] saved_a, saved_b;

  initial begin
    set_idle();
    rst = 1'b1;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Forwarding priority
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 32'h11;
    fwd_wb_we = 1; fwd_wb_rd = 5; fwd_wb_data = 32'h22;
    fwd_ex_we = 1; fwd_ex_rd = 5; fwd_ex_data = 32'h33;
    in_rd_addr = 3; in_rd_we = 1;
    cycle();
    chk("fwd_ex_wins", alu_a, 32'h33);
    fwd_ex_we = 0;
    cycle();
    chk("fwd_wb", alu_a, 32'h22);
    in_rs1_addr = 0; in_rs1_data = 32'h44; in_rd_addr = 0;
    fwd_ex_we = 1; fwd_ex_rd = 0; fwd_wb_rd = 0;
    cycle();
    chk("x0_no_fwd", alu_a, 32'h44);
    chk("rd0_no_we", 32'(out_rd_we), 32'd0);

    // Operand select
    set_idle();
    in_valid = 1; in_a_sel = 1; in_pc = 32'h100; in_b_sel = 1; in_imm = 32'hFFFF_FFFC;
    in_rs2_addr = 7; in_rs2_data = 32'h55;
    fwd_ex_we = 1; fwd_ex_rd = 7; fwd_ex_data = 32'h77;
    cycle();
    chk("sel_pc", alu_a, 32'h100);
    chk("sel_imm", alu_b, 32'hFFFF_FFFC);
    chk("store_fwd", out_rs2_val, 32'h77);

    // Backpressure: held outputs ignore forwarding changes
    set_idle();
    in_valid = 1; in_rs1_addr = 1; in_rs1_data = 32'hABC; in_rs2_addr = 2; in_rs2_data = 32'h123;
    cycle();
    saved_a = alu_a; saved_b = alu_b;
    out_ready = 0; in_rs1_data = 32'h5A5A;
    for (int i = 0; i < 3; i++) begin
      randomize_fwd();
      cycle();
      chk("stall_a", alu_a, 32'hABC);
      chk("stall_b", alu_b, saved_b);
      chk("stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1; in_valid = 1; in_rs1_data = 32'hDEF; fwd_ex_we = 0; fwd_wb_we = 0;
    cycle();
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_a", alu_a, 32'hDEF);

    // Flush beats in_valid while full
    flush = 1; in_valid = 1; out_ready = 0; in_rs1_data = 32'h999;
    cycle();
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush = 0; in_valid = 0;
    cycle();
    chk("flush_nocap", 32'(out_valid), 32'd0);

    // Asynchronous reset while full
    set_idle();
    in_valid = 1; in_rs1_addr = 4; in_rs1_data = 32'h1234;
    cycle();
    chk("pre_rst_a", alu_a, 32'h1234);
    in_valid = 0; out_ready = 0;
    #3; rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    model_reset();
    #1; rst = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);

`ifdef ALU_OP_CHECK_EN
    set_idle();
    in_valid = 1; in_alu_op = 4'b1101;
    cycle();
    chk("illegal_op", 32'(alu_op), 32'd0);
    chk("err_set", 32'(err_illegal_op), 32'd1);
    in_alu_op = 4'b0011;
    cycle();
    chk("err_sticky", 32'(err_illegal_op), 32'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
